dac_serial_tx: RTL and testbench



---
 rtl/dac_pkg.sv | 16 +
 rtl/tick_div.sv | 37 +++
 rtl/dac_serial_tx.sv | 148 ++++++++++++++
 tb/tb_dac_serial_tx.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/dac_pkg.sv
// dac_pkg: shared definitions for the serial DAC transmitter.
//   state_e     - FSM state encoding
//   FRAME_BITS  - bits per DAC frame (4 command + 12 data)
//   CMD_DEFAULT - command nibble sent ahead of the data code
package dac_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_QUIET = 2'd2
  } state_e;

  localparam int         FRAME_BITS  = 16;
  localparam logic [3:0] CMD_DEFAULT = 4'b0000;

endpackage

// File: rtl/tick_div.sv
// tick_div: free-running divider producing a one-cycle tick every DIV cycles.
//   clk       in  system clock
//   rst       in  asynchronous active-low reset
//   en        in  count enable; the counter rests at zero while low
//   clr       in  restart the count so the phase aligns to this cycle
//   tick      out high on the last cycle of each DIV-cycle period
//   tick_next out high when the following cycle will carry a tick
module tick_div #(
  parameter int DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick,
  output logic tick_next
);

  localparam int             CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0]  LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;

  always_comb begin
    tick      = en & (cnt_q == LAST);
    cnt_inc   = tick ? '0 : cnt_q + 1'b1;
    cnt_d     = (clr | ~en) ? '0 : cnt_inc;
    // Lets the parent register a pulse that lands exactly on the tick cycle.
    tick_next = en & (cnt_inc == LAST);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/dac_serial_tx.sv
// dac_serial_tx: shifts a {cmd, offset-binary code} frame to an SPI-style DAC.
//   clk     in  system clock
//   rst     in  asynchronous active-low reset
//   y       in  signed sample, captured only when a load is accepted
//   load    in  one-cycle transmit request
//   sclk    out serial clock, idles high; DAC samples on its falling edge
//   sync_n  out frame enable, active low
//   sdata   out serial data, MSB first
//   busy    out frame or quiet gap in progress
//   done    out one-cycle pulse on the last quiet cycle
//   overrun out one-cycle pulse, one cycle after a load that arrived while busy
//
// state | meaning
// IDLE  | waiting for load
// SHIFT | sync_n low, 32 sclk half-periods of DIV cycles each
// QUIET | sync_n/sclk high for DIV cycles, done on the last one
module dac_serial_tx
  import dac_pkg::*;
#(
  parameter int         CANT_BITS = 25,
  parameter int         DAC_BITS  = 12,
  parameter int         DIV       = 2,
  parameter logic [3:0] CMD       = CMD_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [CANT_BITS-1:0] y,
  input  logic                 load,
  output logic                 sclk,
  output logic                 sync_n,
  output logic                 sdata,
  output logic                 busy,
  output logic                 done,
  output logic                 overrun
);

  localparam int              FW      = 4 + DAC_BITS;
  localparam int              HPW     = $clog2(2 * FW);
  localparam logic [HPW-1:0]  HP_LAST = HPW'(2 * FW - 1);

  state_e          state_q, state_d;
  logic [FW-1:0]   shreg_q, shreg_d;
  logic [HPW-1:0]  hp_q, hp_d;
  logic            sclk_q, sclk_d;
  logic            sync_n_q, sync_n_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            overrun_q, overrun_d;

  logic                accept;
  logic                tick, tick_next;
  logic [DAC_BITS-1:0] code;
  logic                unused_y;

  // Truncate to DAC resolution and flip the sign bit for offset-binary.
  assign code     = {~y[CANT_BITS-1], y[CANT_BITS-2 -: DAC_BITS-1]};
  assign unused_y = ^y[CANT_BITS-DAC_BITS-1:0];
  assign accept   = load & (state_q == ST_IDLE);

  tick_div #(.DIV(DIV)) u_tick_div (
    .clk       (clk),
    .rst       (rst),
    .en        (state_q != ST_IDLE),
    .clr       (accept),
    .tick      (tick),
    .tick_next (tick_next)
  );

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    hp_d      = hp_q;
    sclk_d    = sclk_q;
    sync_n_d  = sync_n_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    overrun_d = load & (state_q != ST_IDLE);
    case (state_q)
      ST_IDLE: begin
        if (load) begin
          state_d  = ST_SHIFT;
          shreg_d  = {CMD, code};
          hp_d     = '0;
          sclk_d   = 1'b1;
          sync_n_d = 1'b0;
          busy_d   = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (tick) begin
          if (hp_q == HP_LAST) begin
            state_d  = ST_QUIET;
            sclk_d   = 1'b1;
            sync_n_d = 1'b1;
            shreg_d  = '0;
            // Only true when DIV=1, i.e. QUIET lasts a single cycle.
            done_d   = tick_next;
          end else begin
            hp_d   = hp_q + 1'b1;
            // Even half-periods are sclk high; a new bit appears as sclk rises.
            sclk_d = ~hp_d[0];
            if (!hp_d[0]) shreg_d = shreg_q << 1;
          end
        end
      end
      ST_QUIET: begin
        if (tick) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          hp_d    = '0;
        end else begin
          done_d = tick_next;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      shreg_q   <= '0;
      hp_q      <= '0;
      sclk_q    <= 1'b1;
      sync_n_q  <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      hp_q      <= hp_d;
      sclk_q    <= sclk_d;
      sync_n_q  <= sync_n_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      overrun_q <= overrun_d;
    end
  end

  assign sclk    = sclk_q;
  assign sync_n  = sync_n_q;
  assign sdata   = shreg_q[FW-1];
  assign busy    = busy_q;
  assign done    = done_q;
  assign overrun = overrun_q;

endmodule

// File: tb/tb_dac_serial_tx.sv
// tb_dac_serial_tx: directed bench for dac_serial_tx with three instances
//   u_a: DIV=2, cmd 0000   u_b: DIV=1, cmd 0011   u_c: DIV=5, cmd 0000
// A per-instance DAC model captures bits on sclk falling edges while sync_n
// is low and latches a frame when sync_n rises after exactly 16 bits.
module tb_dac_serial_tx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [24:0] y   = '0;
  logic [2:0]  load = '0;
  logic [2:0]  sclk_v, sync_n_v, sdata_v, busy_v, done_v, overrun_v;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dac_serial_tx #(.CANT_BITS(25), .DAC_BITS(12), .DIV(2), .CMD(4'b0000)) u_a (
    .clk(clk), .rst(rst), .y(y), .load(load[0]),
    .sclk(sclk_v[0]), .sync_n(sync_n_v[0]), .sdata(sdata_v[0]),
    .busy(busy_v[0]), .done(done_v[0]), .overrun(overrun_v[0]));

  dac_serial_tx #(.CANT_BITS(25), .DAC_BITS(12), .DIV(1), .CMD(4'b0011)) u_b (
    .clk(clk), .rst(rst), .y(y), .load(load[1]),
    .sclk(sclk_v[1]), .sync_n(sync_n_v[1]), .sdata(sdata_v[1]),
    .busy(busy_v[1]), .done(done_v[1]), .overrun(overrun_v[1]));

  dac_serial_tx #(.CANT_BITS(25), .DAC_BITS(12), .DIV(5), .CMD(4'b0000)) u_c (
    .clk(clk), .rst(rst), .y(y), .load(load[2]),
    .sclk(sclk_v[2]), .sync_n(sync_n_v[2]), .sdata(sdata_v[2]),
    .busy(busy_v[2]), .done(done_v[2]), .overrun(overrun_v[2]));

  // DAC model state
  int          cyc = 0;
  logic [15:0] sh      [3] = '{16'h0, 16'h0, 16'h0};
  logic [15:0] frame   [3] = '{16'h0, 16'h0, 16'h0};
  int          frames  [3] = '{0, 0, 0};
  int          bitcnt  [3] = '{0, 0, 0};
  int          pmin    [3] = '{1000, 1000, 1000};
  int          pmax    [3] = '{0, 0, 0};
  int          smin    [3] = '{1000, 1000, 1000};
  int          hmin    [3] = '{1000, 1000, 1000};
  int          last_fall [3] = '{-1000, -1000, -1000};
  int          last_chg  [3] = '{-1000, -1000, -1000};
  bit          have_fall [3] = '{1'b0, 1'b0, 1'b0};
  logic [2:0]  sync_p  = 3'b111;
  logic [2:0]  sclk_p  = 3'b111;
  logic [2:0]  sdata_p = 3'b000;

  always @(negedge clk) begin
    cyc++;
    for (int i = 0; i < 3; i++) begin
      if (sync_p[i] && !sync_n_v[i]) begin
        bitcnt[i] = 0; pmin[i] = 1000; pmax[i] = 0;
        smin[i] = 1000; hmin[i] = 1000; have_fall[i] = 1'b0;
      end
      if (sclk_p[i] && !sclk_v[i] && !sync_n_v[i]) begin
        sh[i] = {sh[i][14:0], sdata_v[i]};
        bitcnt[i]++;
        if (have_fall[i]) begin
          if (cyc - last_fall[i] < pmin[i]) pmin[i] = cyc - last_fall[i];
          if (cyc - last_fall[i] > pmax[i]) pmax[i] = cyc - last_fall[i];
        end
        if (cyc - last_chg[i] < smin[i]) smin[i] = cyc - last_chg[i];
        last_fall[i] = cyc;
        have_fall[i] = 1'b1;
      end
      if (sdata_v[i] !== sdata_p[i]) begin
        if (cyc - last_fall[i] < hmin[i]) hmin[i] = cyc - last_fall[i];
        last_chg[i] = cyc;
      end
      if (!sync_p[i] && sync_n_v[i]) begin
        if (bitcnt[i] == 16) begin
          frame[i] = sh[i];
          frames[i]++;
        end
        bitcnt[i] = 0;
      end
      sync_p[i]  = sync_n_v[i];
      sclk_p[i]  = sclk_v[i];
      sdata_p[i] = sdata_v[i];
    end
  end

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Issues a load to instance i at a negedge and follows it until busy drops.
  // extra_at >= 0 issues a second load during busy cycle number extra_at.
  task automatic frame_test(input int i, input logic [24:0] yv, input int exp_frame,
                            input int div, input int extra_at, input string tag);
    logic [3:0] first_vec;
    int busy_len, done_idx, done_n, ov_n, ov_c, f0;
    f0 = frames[i];
    y = yv;
    load[i] = 1'b1;
    @(negedge clk);
    load[i] = 1'b0;
    first_vec = {busy_v[i], sync_n_v[i], sclk_v[i], sdata_v[i]};
    busy_len = 0; done_idx = 0; done_n = 0; ov_n = 0; ov_c = -1;
    for (int c = 0; c < 400; c++) begin
      load[i] = 1'b0;
      if (busy_v[i]) begin
        busy_len++;
        if (done_v[i]) begin done_n++; done_idx = busy_len; end
      end
      if (overrun_v[i]) begin ov_n++; if (ov_c < 0) ov_c = c; end
      if (!busy_v[i] && busy_len > 0) break;
      if (busy_v[i] && busy_len == extra_at) begin
        load[i] = 1'b1;
        y = ~yv;
      end
      @(negedge clk);
    end
    load[i] = 1'b0;
    chk({tag, "_first"},    int'(first_vec), int'(4'b1010));
    chk({tag, "_busy_len"}, busy_len, 33 * div);
    chk({tag, "_done_idx"}, done_idx, 33 * div);
    chk({tag, "_done_n"},   done_n, 1);
    chk({tag, "_frame"},    int'(frame[i]), exp_frame);
    chk({tag, "_frames"},   frames[i] - f0, 1);
    chk({tag, "_ovr_n"},    ov_n, (extra_at >= 0) ? 1 : 0);
    if (extra_at >= 0) chk({tag, "_ovr_at"}, ov_c, extra_at);
    chk({tag, "_pmin"},     pmin[i], 2 * div);
    chk({tag, "_pmax"},     pmax[i], 2 * div);
    chk({tag, "_setup"},    int'(smin[i] >= div), 1);
    chk({tag, "_hold"},     int'(hmin[i] >= div), 1);
  endtask

  initial begin
    int f0;
    #2 rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 3; i++)
      chk("reset_out",
          int'({sclk_v[i], sync_n_v[i], sdata_v[i], busy_v[i], done_v[i], overrun_v[i]}),
          int'(6'b110000));
    rst = 1'b1;
    repeat (2) @(negedge clk);

    frame_test(0, 25'h0000000, 16'h0800, 2, -1, "a_zero");
    frame_test(0, 25'h0FFFFFF, 16'h0FFF, 2, -1, "a_maxpos");
    frame_test(0, 25'h1000000, 16'h0000, 2, -1, "a_minneg");
    frame_test(0, 25'h1FFFFFF, 16'h07FF, 2, 10, "a_ovr10");
    frame_test(0, 25'h0ABCDEF, 16'h0D5E, 2, 66, "a_ovr_done");

    frame_test(1, 25'h1FFFFFF, 16'h37FF, 1, -1, "b_neg1_cmd3");
    frame_test(1, 25'h1555555, 16'h32AA, 1, -1, "b_alt");
    frame_test(2, 25'h0ABCDEF, 16'h0D5E, 5, -1, "c_div5");
    frame_test(2, 25'h1555555, 16'h02AA, 5, -1, "c_alt");

    // Reset in the middle of a frame, after bit 9 has been sampled.
    f0 = frames[0];
    y = 25'h0000000;
    load[0] = 1'b1;
    @(negedge clk);
    load[0] = 1'b0;
    repeat (29) @(negedge clk);
    chk("mid_busy", int'({busy_v[0], sync_n_v[0]}), int'(2'b10));
    @(posedge clk);
    #1 rst = 1'b0;
    #1 chk("mid_rst_out",
           int'({sclk_v[0], sync_n_v[0], sdata_v[0], busy_v[0], done_v[0], overrun_v[0]}),
           int'(6'b110000));
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("mid_rst_noframe", frames[0] - f0, 0);
    frame_test(0, 25'h1FFFFFF, 16'h07FF, 2, -1, "a_after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
